carry_look_adder: RTL and testbench
===================================

Name: carry_look_adder

Overview:
- Clocked, parameterised carry-lookahead adder: sum = a + b + cin, with carry-out.
- Built from 4-bit lookahead groups plus a second-level lookahead unit across the groups. There is no ripple carry between groups.
- Inputs are sampled and results registered, so the block drops into pipelined datapaths with one cycle of latency.
- An in_valid/out_valid pair tracks which result is live.

Parameters:
- WIDTH, 4: operand width in bits. Legal values are multiples of 4, from 4 to 64. Any other value stops elaboration with a $error.

Ports:
- clk  input  1  clock; every register updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  a, b and cin carry a valid operation this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- sum  output  WIDTH  registered sum bits [WIDTH-1:0].
- carry  output  1  registered carry-out of bit WIDTH-1.
- out_valid  output  1  registered copy of in_valid; high means sum and carry are the result of the operation presented one cycle earlier.

Behaviour:
- Bit level: p[i] = a[i] ^ b[i], g[i] = a[i] & b[i].
- Group level (4 bits): c[i+1] = g[i] | p[i]&c[i], expanded fully in two-level sum-of-products (no chaining). The group also produces GP = &p and GG = g3 | p3g2 | p3p2g1 | p3p2p1g0.
- Second level: group carry-ins are computed from GP/GG and cin by lookahead. Every bit's carry is combinational from the registered-free inputs through a bounded logic depth, independent of WIDTH/4 ripple.
- Sum: s[i] = p[i] ^ c[i]. carry = c[WIDTH].
- Arithmetic: the result is exact modulo 2^(WIDTH+1), i.e. {carry, sum} = a + b + cin. There is no saturation.
- Latency and update rule: exactly 1 cycle. On each rising edge with rst_n = 1:
  - out_valid <= in_valid.
  - If in_valid = 1: sum and carry load the new result.
  - If in_valid = 0: sum and carry hold their previous values.
- Reset: when rst_n = 0 at a rising edge, sum <= 0, carry <= 0, out_valid <= 0, regardless of in_valid. A reset mid-stream discards the in-flight result. The first valid result after reset release appears one cycle after the first in_valid = 1 sampled with rst_n = 1.
- Back-to-back operation: a new operation is accepted every cycle. There is no stall or backpressure input.
- Boundaries:
  - all-ones + all-ones + 1 gives sum all-ones, carry 1.
  - all-ones + 0 + 1 gives sum 0, carry 1; the carry propagates through every group.
- There is no internal state beyond the output registers and out_valid.

Optional Feature:
- Macro: CARRY_LOOK_ADDER_OVF_EN.
- With the macro defined:
  - An extra output port is added: overflow, output, 1 bit.
  - overflow is registered with the same timing, enable and reset as carry, and resets to 0.
  - overflow = c[WIDTH] ^ c[WIDTH-1], the signed two's-complement overflow of a + b + cin.
- Without the macro: the port does not exist, and no logic for it is generated.

Test Plan:
- WIDTH=4, cin=0, in_valid=1: a=5, b=9 -> next cycle sum=4'b1110, carry=0, out_valid=1. Then a=11, b=4 -> sum=4'b1111, carry=0.
- WIDTH=4, cin=0: a=15, b=9 -> sum=4'b1000, carry=1. Then a=2, b=3 -> sum=4'b0101, carry=0.
- Full propagate, WIDTH=16: a=16'hFFFF, b=0, cin=1 -> sum=0, carry=1. Then a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, carry=1.
- Hold and valid: present a=3, b=4 with in_valid=1, then a=9, b=9 with in_valid=0 -> sum stays 7, carry=0, out_valid drops to 0 on the second cycle.
- Reset: rst_n=0 during a valid operation -> next edge sum=0, carry=0, out_valid=0. The first result appears one cycle after release with in_valid=1.
- With CARRY_LOOK_ADDER_OVF_EN, WIDTH=4: a=7, b=1, cin=0 -> sum=4'b1000, overflow=1. Then a=15, b=1 -> sum=0, carry=1, overflow=0.
- Randomised: 10,000 vectors for WIDTH in {4, 8, 32, 64}, checked against a behavioural a+b+cin model one cycle later.

Source files
------------

// File: rtl/carry_look_adder.sv
// carry_look_adder: registered two-level carry-lookahead adder.
// {carry, sum} = a + b + cin, one cycle of latency, with an in_valid/out_valid pair.
// The adder is built from 4-bit lookahead groups. A second-level lookahead unit
// works across the groups, so no carry ripples from one group to the next.
// Optional feature: define CARRY_LOOK_ADDER_OVF_EN to add a registered signed
// overflow output. Without it, that port and its logic do not exist.

module carry_look_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
`ifdef CARRY_LOOK_ADDER_OVF_EN
  output logic             overflow,
`endif
  output logic             out_valid
);

  // Number of 4-bit lookahead groups. It is clamped to 1 so that the
  // declarations stay legal while the width check below reports the error.
  localparam int NGRP = (WIDTH >= 4) ? (WIDTH / 4) : 1;

  genvar gi, gj;

  // Only whole groups of 4 bits are supported, up to 16 groups.
  if ((WIDTH % 4 != 0) || (WIDTH < 4) || (WIDTH > 64)) begin : g_bad_width
    $error("carry_look_adder: WIDTH=%0d is illegal (multiple of 4 in 4..64 required)", WIDTH);
  end

  // ---------------------------------------------------------------------------
  // Bit level: propagate and generate terms
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   c;         // c[i] is the carry into bit i; c[WIDTH] is the carry-out
  logic [NGRP-1:0]  grp_p;     // group propagate (all four bits propagate)
  logic [NGRP-1:0]  grp_g;     // group generate (a carry leaves the group on its own)
  logic [NGRP:0]    grp_cin;   // carry into each group; the top entry is the carry-out

  for (gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign p[gi] = a[gi] ^ b[gi];
    assign g[gi] = a[gi] & b[gi];
  end

  // ---------------------------------------------------------------------------
  // Group level: fully expanded 4-bit lookahead. Each carry is a flat
  // sum-of-products built from the group carry-in, so carries do not chain.
  // ---------------------------------------------------------------------------
  for (gi = 0; gi < NGRP; gi++) begin : g_group
    localparam int BASE = 4 * gi;

    logic [3:0] gp;
    logic [3:0] gg;
    logic       c0;

    assign gp = p[BASE+3:BASE];
    assign gg = g[BASE+3:BASE];
    assign c0 = grp_cin[gi];

    assign c[BASE]   = c0;
    assign c[BASE+1] = gg[0]
                     | (gp[0] & c0);
    assign c[BASE+2] = gg[1]
                     | (gp[1] & gg[0])
                     | (gp[1] & gp[0] & c0);
    assign c[BASE+3] = gg[2]
                     | (gp[2] & gg[1])
                     | (gp[2] & gp[1] & gg[0])
                     | (gp[2] & gp[1] & gp[0] & c0);

    // The second level uses these group summaries. It does not use c[BASE+4].
    assign grp_p[gi] = &gp;
    assign grp_g[gi] = gg[3]
                     | (gp[3] & gg[2])
                     | (gp[3] & gp[2] & gg[1])
                     | (gp[3] & gp[2] & gp[1] & gg[0]);
  end

  // ---------------------------------------------------------------------------
  // Second level: the carry into group k is the OR of one product term per
  // possible carry source. Each lower group j can generate a carry that every
  // group between j and k propagates. The cin term counts only when all lower
  // groups propagate. Depth is one AND level plus one OR level for any WIDTH.
  // ---------------------------------------------------------------------------
  for (gi = 0; gi <= NGRP; gi++) begin : g_lookahead
    logic [gi:0] term;

    for (gj = 0; gj < gi; gj++) begin : g_term
      if (gj == gi - 1) begin : g_adjacent
        assign term[gj] = grp_g[gj];
      end else begin : g_spanning
        assign term[gj] = grp_g[gj] & (&grp_p[gi-1:gj+1]);
      end
    end

    if (gi == 0) begin : g_cin_direct
      assign term[0] = cin;
    end else begin : g_cin_through
      assign term[gi] = cin & (&grp_p[gi-1:0]);
    end

    assign grp_cin[gi] = |term;
  end

  assign c[WIDTH] = grp_cin[NGRP];

  // ---------------------------------------------------------------------------
  // Sum bits and the values loaded into the output registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_next;
  logic             carry_next;

  assign sum_next   = p ^ c[WIDTH-1:0];
  assign carry_next = c[WIDTH];

  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             valid_reg;

  // Output registers: clear on reset; otherwise track in_valid and load a new result only when it is valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        sum_reg   <= sum_next;
        carry_reg <= carry_next;
      end
    end
  end

  assign sum       = sum_reg;
  assign carry     = carry_reg;
  assign out_valid = valid_reg;

`ifdef CARRY_LOOK_ADDER_OVF_EN
  // Signed overflow: the carry into the sign bit differs from the carry out of it.
  logic ovf_next;
  logic ovf_reg;

  assign ovf_next = c[WIDTH] ^ c[WIDTH-1];

  // Overflow register: same reset and load enable as carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (in_valid) begin
      ovf_reg <= ovf_next;
    end
  end

  assign overflow = ovf_reg;
`endif

endmodule

// File: tb/tb_carry_look_adder.sv
// tb_carry_look_adder: self-checking bench for carry_look_adder.
// It runs five instances (WIDTH 4, 8, 16, 32, 64) in parallel on shared operands,
// each instance taking the low bits of the operands.
// The reference model is plain integer arithmetic on the truncated operands.
// When CARRY_LOOK_ADDER_OVF_EN is defined, the overflow output is checked as well.

module tb_carry_look_adder;

  localparam int NW = 5;
  localparam int WLIST [NW] = '{4, 8, 16, 32, 64};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] a_drv;
  logic [63:0] b_drv;
  logic        cin;

  logic [3:0]  sum4;
  logic [7:0]  sum8;
  logic [15:0] sum16;
  logic [31:0] sum32;
  logic [63:0] sum64;
  logic [NW-1:0] carry_o;
  logic [NW-1:0] valid_o;
  logic [NW-1:0] ovf_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: the value each output should show after the latest edge.
  logic [63:0]   exp_sum [NW];
  logic [NW-1:0] exp_carry;
  logic [NW-1:0] exp_ovf;
  logic          exp_valid;

  logic [63:0] obs_sum [NW];

  always #5 clk = ~clk;

  carry_look_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a_drv[3:0]), .b(b_drv[3:0]), .cin(cin),
    .sum(sum4), .carry(carry_o[0]),
`ifdef CARRY_LOOK_ADDER_OVF_EN
    .overflow(ovf_o[0]),
`endif
    .out_valid(valid_o[0])
  );

  carry_look_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a_drv[7:0]), .b(b_drv[7:0]), .cin(cin),
    .sum(sum8), .carry(carry_o[1]),
`ifdef CARRY_LOOK_ADDER_OVF_EN
    .overflow(ovf_o[1]),
`endif
    .out_valid(valid_o[1])
  );

  carry_look_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a_drv[15:0]), .b(b_drv[15:0]), .cin(cin),
    .sum(sum16), .carry(carry_o[2]),
`ifdef CARRY_LOOK_ADDER_OVF_EN
    .overflow(ovf_o[2]),
`endif
    .out_valid(valid_o[2])
  );

  carry_look_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a_drv[31:0]), .b(b_drv[31:0]), .cin(cin),
    .sum(sum32), .carry(carry_o[3]),
`ifdef CARRY_LOOK_ADDER_OVF_EN
    .overflow(ovf_o[3]),
`endif
    .out_valid(valid_o[3])
  );

  carry_look_adder #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a_drv), .b(b_drv), .cin(cin),
    .sum(sum64), .carry(carry_o[4]),
`ifdef CARRY_LOOK_ADDER_OVF_EN
    .overflow(ovf_o[4]),
`endif
    .out_valid(valid_o[4])
  );

`ifndef CARRY_LOOK_ADDER_OVF_EN
  assign ovf_o = '0;
`endif

  assign obs_sum[0] = 64'(sum4);
  assign obs_sum[1] = 64'(sum8);
  assign obs_sum[2] = 64'(sum16);
  assign obs_sum[3] = 64'(sum32);
  assign obs_sum[4] = sum64;

  // Single comparison point: counts every check and reports each mismatch.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: W-bit unsigned add giving {carry, sum}, plus the signed range test for overflow.
  task automatic ref_add(input int w, input logic [63:0] a, input logic [63:0] b, input logic ci,
                         output logic [63:0] s, output logic co, output logic ov);
    logic [63:0]        mask;
    logic [64:0]        total;
    logic signed [67:0] sa, sb, st, lim;
    mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    total = {1'b0, a & mask} + {1'b0, b & mask} + 65'(ci);
    s     = total[63:0] & mask;
    co    = total[w];
    sa    = $signed({4'b0, a & mask});
    sb    = $signed({4'b0, b & mask});
    if (a[w-1]) sa = sa - (68'sd1 <<< w);
    if (b[w-1]) sb = sb - (68'sd1 <<< w);
    st    = sa + sb + $signed({67'd0, ci});
    lim   = 68'sd1 <<< (w - 1);
    ov    = (st >= lim) || (st < -lim);
  endtask

  // One clock edge: advance the model with the driven inputs, then compare every instance.
  task automatic tick();
    logic [63:0] s;
    logic        co, ov;
    @(posedge clk);
    if (!rst_n) begin
      for (int w = 0; w < NW; w++) exp_sum[w] = '0;
      exp_carry = '0;
      exp_ovf   = '0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = in_valid;
      if (in_valid) begin
        for (int w = 0; w < NW; w++) begin
          ref_add(WLIST[w], a_drv, b_drv, cin, s, co, ov);
          exp_sum[w]   = s;
          exp_carry[w] = co;
          exp_ovf[w]   = ov;
        end
      end
    end
    #1;
    for (int w = 0; w < NW; w++) begin
      check($sformatf("sum_w%0d", WLIST[w]), obs_sum[w], exp_sum[w]);
      check($sformatf("carry_w%0d", WLIST[w]), 64'(carry_o[w]), 64'(exp_carry[w]));
      check($sformatf("valid_w%0d", WLIST[w]), 64'(valid_o[w]), 64'(exp_valid));
`ifdef CARRY_LOOK_ADDER_OVF_EN
      check($sformatf("ovf_w%0d", WLIST[w]), 64'(ovf_o[w]), 64'(exp_ovf[w]));
`endif
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b, input logic ci);
    in_valid = v;
    a_drv    = a;
    b_drv    = b;
    cin      = ci;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 64'd5, 64'd9, 1'b0);
    tick();
    tick();
    check("reset_sum4", obs_sum[0], 64'd0);
    check("reset_valid4", 64'(valid_o[0]), 64'd0);
    $display("reset: sum4=%0h valid=%0b", sum4, valid_o[0]);

    // Small 4-bit additions
    rst_n = 1'b1;
    drive(1'b1, 64'd5, 64'd9, 1'b0);  tick();
    check("tp1_sum4", obs_sum[0], 64'hE);
    check("tp1_carry4", 64'(carry_o[0]), 64'd0);
    check("tp1_valid4", 64'(valid_o[0]), 64'd1);
    $display("5+9: sum4=%0h carry=%0b", sum4, carry_o[0]);
    drive(1'b1, 64'd11, 64'd4, 1'b0); tick();
    check("tp1b_sum4", obs_sum[0], 64'hF);
    $display("11+4: sum4=%0h carry=%0b", sum4, carry_o[0]);
    drive(1'b1, 64'd15, 64'd9, 1'b0); tick();
    check("tp2_sum4", obs_sum[0], 64'h8);
    check("tp2_carry4", 64'(carry_o[0]), 64'd1);
    $display("15+9: sum4=%0h carry=%0b", sum4, carry_o[0]);
    drive(1'b1, 64'd2, 64'd3, 1'b0);  tick();
    check("tp2b_sum4", obs_sum[0], 64'h5);
    check("tp2b_carry4", 64'(carry_o[0]), 64'd0);
    $display("2+3: sum4=%0h carry=%0b", sum4, carry_o[0]);

    // Full propagate through every group
    drive(1'b1, 64'hFFFF, 64'd0, 1'b1); tick();
    check("fp_sum16", obs_sum[2], 64'd0);
    check("fp_carry16", 64'(carry_o[2]), 64'd1);
    $display("FFFF+0+1: sum16=%0h carry=%0b", sum16, carry_o[2]);
    drive(1'b1, 64'hFFFF, 64'hFFFF, 1'b1); tick();
    check("fg_sum16", obs_sum[2], 64'hFFFF);
    check("fg_carry16", 64'(carry_o[2]), 64'd1);
    $display("FFFF+FFFF+1: sum16=%0h carry=%0b", sum16, carry_o[2]);
    drive(1'b1, '1, 64'd0, 1'b1); tick();
    check("fp_sum64", obs_sum[4], 64'd0);
    check("fp_carry64", 64'(carry_o[4]), 64'd1);
    $display("ones64+0+1: sum64=%0h carry=%0b", sum64, carry_o[4]);

    // Hold when in_valid is low
    drive(1'b1, 64'd3, 64'd4, 1'b0); tick();
    drive(1'b0, 64'd9, 64'd9, 1'b0); tick();
    check("hold_sum4", obs_sum[0], 64'd7);
    check("hold_valid4", 64'(valid_o[0]), 64'd0);
    $display("hold: sum4=%0h valid=%0b", sum4, valid_o[0]);

    // Reset in mid-stream, then the first result after release
    rst_n = 1'b0;
    drive(1'b1, 64'd6, 64'd6, 1'b1); tick();
    check("midrst_sum4", obs_sum[0], 64'd0);
    check("midrst_valid4", 64'(valid_o[0]), 64'd0);
    rst_n = 1'b1;
    drive(1'b1, 64'd1, 64'd2, 1'b0); tick();
    check("rel_sum4", obs_sum[0], 64'd3);
    check("rel_valid4", 64'(valid_o[0]), 64'd1);
    $display("after reset: sum4=%0h valid=%0b", sum4, valid_o[0]);

    // Signed overflow
    drive(1'b1, 64'd7, 64'd1, 1'b0); tick();
    check("ovf_sum4", obs_sum[0], 64'h8);
`ifdef CARRY_LOOK_ADDER_OVF_EN
    check("ovf_flag4", 64'(ovf_o[0]), 64'd1);
`endif
    $display("7+1: sum4=%0h ovf=%0b", sum4, ovf_o[0]);
    drive(1'b1, 64'd15, 64'd1, 1'b0); tick();
    check("novf_sum4", obs_sum[0], 64'd0);
    check("novf_carry4", 64'(carry_o[0]), 64'd1);
`ifdef CARRY_LOOK_ADDER_OVF_EN
    check("novf_flag4", 64'(ovf_o[0]), 64'd0);
`endif
    $display("15+1: sum4=%0h carry=%0b ovf=%0b", sum4, carry_o[0], ovf_o[0]);

    // Random operands with a bias toward edge values, random valid gaps and occasional reset
    for (int i = 0; i < 10000; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0: ra = '1;
        1: rb = '1;
        2: rb = ~ra;
        3: rb = '0;
        default: ;
      endcase
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 4) != 0, ra, rb, 1'($urandom_range(0, 1)));
      tick();
      if (i % 1000 == 999)
        $display("random batch %0d: compared=%0d mismatched=%0d", i / 1000, n_cmp, n_bad);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
